matrix_scan_controller: RTL and testbench
=========================================

# matrix_scan_controller

Column-multiplexing scan controller for the 5×7 LED matrix on the CPLD kit. It holds the current water level and presents it to `water_level_decoder` as `dec_data`. It scans the five columns one at a time with a blanking gap between them, maps the decoder's two column images onto the physical columns, and blinks the display while the level is critical. New levels arrive through a valid/ack handshake and are applied only at frame boundaries, so a frame never shows two different images.

## Interface
- `SCAN_DIV`, 1000: clocks per column slot (blank + drive); constraint `SCAN_DIV > BLANK_CYCLES`
- `BLANK_CYCLES`, 2: clocks with all columns off at the start of each slot; ≥1
- `BLINK_FRAMES`, 50: frames per blink half-period; ≥1

- `clk` in 1: single system clock
- `reset_n` in 1: asynchronous, active-low reset
- `enable` in 1: 1 = scan the display, 0 = display dark
- `level_in` in 2: new water level (00 critical, 01 low, 10 mid, 11 high)
- `level_valid` in 1: `level_in` is valid; held until `level_ack`
- `level_ack` out 1: one-cycle pulse, `level_in` latched
- `dec_data` out 2: to the decoder, equals the latched level
- `dec_col_0` in 7: decoder image for columns 1–3, 1 = lit
- `dec_col_1` in 7: decoder image for columns 0 and 4, 1 = lit
- `col_sel_n` out 5: active-low one-hot column select
- `row_n` out 7: active-low row drive
- `frame_start` out 1: one-cycle pulse when column 0 of a new frame begins

## Operation
- Reset values:
  - state `OFF`; `col_sel_n` = 5'b11111; `row_n` = 7'h7F
  - `level_ack` = 0; `frame_start` = 0
  - latched level = 2'b00; column index = 0; slot counter = 0; blink counter = 0; blink phase = visible
- States: `OFF`, `BLANK`, `DRIVE`.
- `OFF`: outputs dark.
  - `enable` = 1 → `BLANK` with column 0, counter 0, and `frame_start` pulsed.
  - `level_valid` = 1 in `OFF` → latch `level_in` and pulse `level_ack` immediately.
- `BLANK`: `col_sel_n` all 1, `row_n` all 1 for `BLANK_CYCLES` clocks, then → `DRIVE`.
- `DRIVE`: drives the current column for `SCAN_DIV - BLANK_CYCLES` clocks.
  - `col_sel_n[col]` = 0.
  - `row_n` = ~`dec_col_1` for columns 0 and 4; ~`dec_col_0` for columns 1–3.
  - During a dark blink phase, `row_n` = 7'h7F while columns keep scanning.
- End of `DRIVE`: → `BLANK` with column+1. Column 4 wraps to 0; that wrap is the frame boundary.
- At the frame boundary:
  - Pulse `frame_start`.
  - If `level_valid` = 1, latch `level_in` and pulse `level_ack`.
  - Advance the blink counter.
- Blink:
  - Active only while the latched level is 00.
  - The counter counts frames 0..`BLINK_FRAMES`-1; phase toggles on wrap.
  - A latched level other than 00 clears the counter and forces phase visible in the same update.
- Handshake:
  - Producer holds `level_in` stable while `level_valid` = 1.
  - Producer deasserts `level_valid` in the cycle after `level_ack`.
  - A `level_valid` still high at a later boundary is re-latched and re-acked. This is legal, not an error.
- `enable` falls in any state → `OFF` on the next edge, outputs dark. A pending level stays pending.
- `enable` rising again restarts at column 0 with `BLANK`.
- `reset_n` asserted mid-operation: all outputs and registers return to their reset values immediately (asynchronous), not at the next edge.

## Timing
- All outputs are registered. `dec_data` comes straight from the level register.
- Edge at which `enable` is first sampled high = cycle 0. Then:
  - `BLANK` occupies cycles 1..`BLANK_CYCLES`.
  - Column 0 drives cycles `BLANK_CYCLES`+1..`SCAN_DIV`.
  - Column k slot starts at cycle 1 + k·`SCAN_DIV`.
- Frame period = 5·`SCAN_DIV` clocks.
- `frame_start` is high in the first `BLANK` cycle of column 0.
- Level update at a boundary:
  - `level_ack` and the new `dec_data` appear in that same first `BLANK` cycle.
  - The decoder image is settled well before `DRIVE` starts, since `BLANK_CYCLES` ≥ 1.
- Counter widths: slot counter `$clog2(SCAN_DIV)`, blink counter `$clog2(BLINK_FRAMES)+1`, column index 3 bits. Column index never exceeds 4.

## Structure
- Shared package `matrix_pkg`:
  - level encodings `LVL_CRITICAL`, `LVL_LOW`, `LVL_MID`, `LVL_HIGH`
  - `NUM_COLS` = 5, `NUM_ROWS` = 7
  - `scan_state_t` enum (`OFF`, `BLANK`, `DRIVE`)
- The decoder stays a separate instance beside this block; this block does not instantiate it.
- One sub-module, `blink_timer`: frame-tick input, clear input, phase output.

## Test plan
- Bench parameters: `SCAN_DIV`=8, `BLANK_CYCLES`=2, `BLINK_FRAMES`=2. Decoder stub: `dec_col_0`=7'h0F, `dec_col_1`=7'h07.
- Reset: pulse `reset_n` low mid-`DRIVE` column 3 → `col_sel_n`=11111, `row_n`=7F, `dec_data`=00 immediately, before the next edge.
- Scan order, level 11 latched: `col_sel_n` = 11110 on cycles 3–8, 11101 on cycles 11–16, and so on to 01111. `row_n` = 7'h78 on columns 0 and 4, 7'h70 on columns 1–3. `frame_start` pulses every 40 cycles.
- Mid-frame update: assert `level_valid` with `level_in`=10 during column 2 → `dec_data` unchanged until the column-0 boundary. There, `level_ack`=1 for one cycle and `dec_data`=10.
- Critical blink: latch 00 → 2 frames lit, 2 frames with `row_n`=7F while `col_sel_n` keeps scanning, repeating.
- Leave critical: 00 → 11 latched during a dark phase → display visible from that same frame.
- Enable drop: `enable`=0 during column 1 `DRIVE` → dark on the next edge. Re-enable → `BLANK` then column 0; `frame_start` pulses.

Source files
------------

// File: rtl/matrix_pkg.sv
// Shared definitions for the LED matrix scan controller.
//   - Water level encodings presented to the decoder.
//   - Matrix geometry (columns x rows).
//   - Scan FSM state type.
//   - Helpers mapping a column index to its active-low select pattern and to
//     the decoder image it shows.
package matrix_pkg;

    localparam logic [1:0] LVL_CRITICAL = 2'b00;
    localparam logic [1:0] LVL_LOW      = 2'b01;
    localparam logic [1:0] LVL_MID      = 2'b10;
    localparam logic [1:0] LVL_HIGH     = 2'b11;

    localparam int NUM_COLS = 5;
    localparam int NUM_ROWS = 7;

    typedef enum logic [1:0] {
        OFF   = 2'b00,
        BLANK = 2'b01,
        DRIVE = 2'b10
    } scan_state_t;

    // Active-low one-hot column select. Out-of-range indices give all columns off.
    function automatic logic [NUM_COLS-1:0] col_onehot_n(input logic [2:0] col);
        logic [NUM_COLS-1:0] sel;
        case (col)
            3'd0:    sel = 5'b11110;
            3'd1:    sel = 5'b11101;
            3'd2:    sel = 5'b11011;
            3'd3:    sel = 5'b10111;
            3'd4:    sel = 5'b01111;
            default: sel = 5'b11111;
        endcase
        return sel;
    endfunction

    // The outer columns (0 and 4) show the decoder's second image; 1-3 the first.
    function automatic logic is_outer_col(input logic [2:0] col);
        return (col == 3'd0) || (col == 3'd4);
    endfunction

endpackage

// File: rtl/blink_timer.sv
// Blink phase generator for the critical-level display.
//   clk          : system clock
//   reset_n      : asynchronous active-low reset
//   frame_tick_i : one-cycle pulse at each frame boundary
//   clear_i      : hold counter at zero and phase visible
//   dark_o       : 1 = blank the rows for this half-period (registered)
// The counter runs over frames 0..BLINK_FRAMES-1 and toggles the phase on wrap.
module blink_timer #(
    parameter int BLINK_FRAMES = 50
) (
    input  logic clk,
    input  logic reset_n,
    input  logic frame_tick_i,
    input  logic clear_i,
    output logic dark_o
);

    localparam int CW = $clog2(BLINK_FRAMES) + 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          dark_q, dark_d;

    // Next-state logic: clear has priority over counting so a level change
    // takes effect in the same update as the frame tick.
    always_comb begin
        cnt_d  = cnt_q;
        dark_d = dark_q;
        if (clear_i) begin
            cnt_d  = '0;
            dark_d = 1'b0;
        end else if (frame_tick_i) begin
            if (cnt_q == CW'(BLINK_FRAMES - 1)) begin
                cnt_d  = '0;
                dark_d = ~dark_q;
            end else begin
                cnt_d  = cnt_q + CW'(1);
            end
        end else begin
            cnt_d  = cnt_q;
        end
    end

    // Counter and phase registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q  <= '0;
            dark_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            dark_q <= dark_d;
        end
    end

    assign dark_o = dark_q;

endmodule

// File: rtl/matrix_scan_controller.sv
// Column-multiplexing scan controller for the 5x7 LED matrix.
//   clk, reset_n           : system clock, asynchronous active-low reset
//   enable                 : 1 = scan, 0 = dark
//   level_in, level_valid  : new water level and its valid flag (held until ack)
//   level_ack              : one-cycle pulse when level_in has been latched
//   dec_data               : latched level, feeds the external decoder
//   dec_col_0, dec_col_1   : decoder images for columns 1-3 and columns 0/4
//   col_sel_n, row_n       : active-low column select and row drive
//   frame_start            : pulse in the first blank cycle of column 0
// Each column slot is SCAN_DIV clocks: BLANK_CYCLES dark, then drive. New
// levels are only taken at frame boundaries (or while OFF) so a frame never
// mixes two images. All outputs are registered from next-state values.
module matrix_scan_controller
    import matrix_pkg::*;
#(
    parameter int SCAN_DIV     = 1000,
    parameter int BLANK_CYCLES = 2,
    parameter int BLINK_FRAMES = 50
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                enable,
    input  logic [1:0]          level_in,
    input  logic                level_valid,
    output logic                level_ack,
    output logic [1:0]          dec_data,
    input  logic [NUM_ROWS-1:0] dec_col_0,
    input  logic [NUM_ROWS-1:0] dec_col_1,
    output logic [NUM_COLS-1:0] col_sel_n,
    output logic [NUM_ROWS-1:0] row_n,
    output logic                frame_start
);

    localparam int SW = $clog2(SCAN_DIV);

    scan_state_t         state_q, state_d;
    logic [2:0]          col_q, col_d;
    logic [SW-1:0]       slot_q, slot_d;
    logic [1:0]          level_q, level_d;
    logic                ack_q, ack_d;
    logic                fs_q, fs_d;
    logic [NUM_COLS-1:0] col_sel_q, col_sel_d;
    logic [NUM_ROWS-1:0] row_q, row_d;
    logic                blink_tick_s;
    logic                blink_clear_s;
    logic                blink_dark_s;

    // Scan FSM next state, level latching and output pre-computation.
    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        slot_d       = slot_q;
        level_d      = level_q;
        ack_d        = 1'b0;
        fs_d         = 1'b0;
        blink_tick_s = 1'b0;

        case (state_q)
            OFF: begin
                // While dark the level is taken straight away; ack_q gating
                // keeps a valid that is still high on the ack cycle from
                // producing a second ack.
                if (level_valid && !ack_q) begin
                    level_d = level_in;
                    ack_d   = 1'b1;
                end else begin
                    level_d = level_q;
                end
                if (enable) begin
                    state_d = BLANK;
                    col_d   = 3'd0;
                    slot_d  = '0;
                    fs_d    = 1'b1;
                end else begin
                    state_d = OFF;
                end
            end
            BLANK: begin
                if (!enable) begin
                    state_d = OFF;
                    col_d   = 3'd0;
                    slot_d  = '0;
                end else if (slot_q == SW'(BLANK_CYCLES - 1)) begin
                    state_d = DRIVE;
                    slot_d  = slot_q + SW'(1);
                end else begin
                    slot_d  = slot_q + SW'(1);
                end
            end
            DRIVE: begin
                if (!enable) begin
                    state_d = OFF;
                    col_d   = 3'd0;
                    slot_d  = '0;
                end else if (slot_q == SW'(SCAN_DIV - 1)) begin
                    state_d = BLANK;
                    slot_d  = '0;
                    if (col_q == 3'd4) begin
                        // Frame boundary.
                        col_d        = 3'd0;
                        fs_d         = 1'b1;
                        blink_tick_s = 1'b1;
                        if (level_valid && !ack_q) begin
                            level_d = level_in;
                            ack_d   = 1'b1;
                        end else begin
                            level_d = level_q;
                        end
                    end else begin
                        col_d = col_q + 3'd1;
                    end
                end else begin
                    slot_d = slot_q + SW'(1);
                end
            end
            default: begin
                state_d = OFF;
                col_d   = 3'd0;
                slot_d  = '0;
            end
        endcase

        if (state_d == DRIVE) begin
            col_sel_d = col_onehot_n(col_d);
            if (blink_dark_s) begin
                row_d = 7'h7F;
            end else if (is_outer_col(col_d)) begin
                row_d = ~dec_col_1;
            end else begin
                row_d = ~dec_col_0;
            end
        end else begin
            col_sel_d = 5'b11111;
            row_d     = 7'h7F;
        end
    end

    // Blinking runs only across boundaries where the level stays critical;
    // entering or leaving critical restarts from a visible phase.
    assign blink_clear_s = (level_q != LVL_CRITICAL) || (level_d != LVL_CRITICAL);

    blink_timer #(
        .BLINK_FRAMES (BLINK_FRAMES)
    ) u_blink_timer (
        .clk          (clk),
        .reset_n      (reset_n),
        .frame_tick_i (blink_tick_s),
        .clear_i      (blink_clear_s),
        .dark_o       (blink_dark_s)
    );

    // State, level and registered output flops.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= OFF;
            col_q     <= 3'd0;
            slot_q    <= '0;
            level_q   <= 2'b00;
            ack_q     <= 1'b0;
            fs_q      <= 1'b0;
            col_sel_q <= 5'b11111;
            row_q     <= 7'h7F;
        end else begin
            state_q   <= state_d;
            col_q     <= col_d;
            slot_q    <= slot_d;
            level_q   <= level_d;
            ack_q     <= ack_d;
            fs_q      <= fs_d;
            col_sel_q <= col_sel_d;
            row_q     <= row_d;
        end
    end

    assign level_ack   = ack_q;
    assign dec_data    = level_q;
    assign col_sel_n   = col_sel_q;
    assign row_n       = row_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_matrix_scan_controller.sv
// Scoreboard bench for matrix_scan_controller. The stimulus process predicts
// each cycle's outputs from the scan rules (position in frame, latched level,
// count of critical frames) and queues them; a monitor pops and compares.
module tb_matrix_scan_controller;

    localparam int SD    = 8;
    localparam int BC    = 2;
    localparam int BF    = 2;
    localparam int FRAME = 5 * SD;
    localparam logic [6:0] DEC0 = 7'h0F;
    localparam logic [6:0] DEC1 = 7'h07;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       enable;
    logic [1:0] level_in;
    logic       level_valid;
    logic       level_ack;
    logic [1:0] dec_data;
    logic [6:0] dec_col_0;
    logic [6:0] dec_col_1;
    logic [4:0] col_sel_n;
    logic [6:0] row_n;
    logic       frame_start;

    always #5 clk = ~clk;

    matrix_scan_controller #(
        .SCAN_DIV     (SD),
        .BLANK_CYCLES (BC),
        .BLINK_FRAMES (BF)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .enable      (enable),
        .level_in    (level_in),
        .level_valid (level_valid),
        .level_ack   (level_ack),
        .dec_data    (dec_data),
        .dec_col_0   (dec_col_0),
        .dec_col_1   (dec_col_1),
        .col_sel_n   (col_sel_n),
        .row_n       (row_n),
        .frame_start (frame_start)
    );

    typedef struct packed {
        logic [4:0] cs;
        logic [6:0] row;
        logic       fs;
        logic       ack;
        logic [1:0] dd;
    } exp_t;

    exp_t       exp_q[$];
    logic [1:0] ack_q[$];
    int         checks   = 0;
    int         failures = 0;

    // Reference model state
    bit         m_run      = 1'b0;
    int         m_t        = 0;
    logic [1:0] m_lvl      = 2'b00;
    int         m_crit     = 0;
    bit         m_ack_prev = 1'b0;

    // Stimulus requests, applied at the next negedge
    bit         want_en   = 1'b0;
    bit         start_req = 1'b0;
    logic [1:0] start_lvl = 2'b00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic int m_col();
        return ((m_t - 1) % FRAME) / SD;
    endfunction

    function automatic bit m_drive();
        return m_run && ((((m_t - 1) % FRAME) % SD) >= BC);
    endfunction

    function automatic bit m_dark();
        return ((m_crit / BF) % 2) == 1;
    endfunction

    // Apply requested inputs for the coming edge and queue the predicted outputs.
    task automatic apply_and_model();
        exp_t       e;
        logic [1:0] old;
        bit         latch;
        bit         boundary;
        int         p;
        int         col;
        if (m_ack_prev) level_valid = 1'b0;
        enable = want_en;
        if (start_req && !level_valid) begin
            level_valid = 1'b1;
            level_in    = start_lvl;
        end
        start_req = 1'b0;

        old      = m_lvl;
        latch    = 1'b0;
        boundary = 1'b0;
        e.fs     = 1'b0;
        if (!m_run) begin
            if (level_valid) latch = 1'b1;
            if (enable) begin
                m_run = 1'b1;
                m_t   = 1;
                e.fs  = 1'b1;
            end
        end else if (!enable) begin
            m_run = 1'b0;
        end else begin
            m_t++;
            if ((m_t - 1) % FRAME == 0) begin
                boundary = 1'b1;
                e.fs     = 1'b1;
                if (level_valid) latch = 1'b1;
            end
        end
        if (latch) m_lvl = level_in;
        if (old != 2'b00 || m_lvl != 2'b00) m_crit = 0;
        else if (boundary) m_crit++;

        e.cs  = 5'h1F;
        e.row = 7'h7F;
        if (m_run) begin
            p   = (m_t - 1) % FRAME;
            col = p / SD;
            if ((p % SD) >= BC) begin
                e.cs = ~(5'b00001 << col);
                if (!m_dark()) e.row = (col == 0 || col == 4) ? ~DEC1 : ~DEC0;
            end
        end
        e.ack = latch;
        e.dd  = m_lvl;
        exp_q.push_back(e);
        if (latch) ack_q.push_back(m_lvl);
        m_ack_prev = latch;
    endtask

    task automatic tick();
        @(negedge clk);
        apply_and_model();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Advance until the model is driving column col (and dark if need_dark).
    task automatic wait_drive(input int col, input bit need_dark, input string name);
        int k = 0;
        while (!(m_drive() && m_col() == col && (!need_dark || m_dark())) && k < 8 * FRAME) begin
            tick();
            k++;
        end
        if (!(m_drive() && m_col() == col && (!need_dark || m_dark()))) begin
            checks++;
            failures++;
            $display("FAIL %s: wait timed out after %0d cycles", name, k);
        end
    endtask

    // Monitor: compare each cycle's outputs, and match every ack to its level.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("col_sel_n",   32'(col_sel_n),   32'(e.cs));
                check("row_n",       32'(row_n),       32'(e.row));
                check("frame_start", 32'(frame_start), 32'(e.fs));
                check("level_ack",   32'(level_ack),   32'(e.ack));
                check("dec_data",    32'(dec_data),    32'(e.dd));
                if (level_ack === 1'b1) begin
                    if (ack_q.size() > 0) check("ack_level", 32'(dec_data), 32'(ack_q.pop_front()));
                    else check("ack_without_request", 32'(level_ack), 32'd0);
                end
            end
        end
    end

    initial begin
        reset_n     = 1'b0;
        enable      = 1'b0;
        level_valid = 1'b0;
        level_in    = 2'b00;
        dec_col_0   = DEC0;
        dec_col_1   = DEC1;
        repeat (3) @(negedge clk);
        check("reset_col_sel_n",   32'(col_sel_n),   32'h1F);
        check("reset_row_n",       32'(row_n),       32'h7F);
        check("reset_dec_data",    32'(dec_data),    32'h0);
        check("reset_level_ack",   32'(level_ack),   32'h0);
        check("reset_frame_start", 32'(frame_start), 32'h0);
        reset_n = 1'b1;

        // Level 11 taken while OFF, then scan two frames
        start_req = 1'b1; start_lvl = 2'b11;
        tick();
        want_en = 1'b1;
        run(2 * FRAME + 3);

        // Mid-frame request during column 2: held until the frame boundary
        wait_drive(2, 1'b0, "wait_col2");
        start_req = 1'b1; start_lvl = 2'b10;
        run(2 * FRAME);

        // Enter critical and watch the blink pattern
        start_req = 1'b1; start_lvl = 2'b00;
        run(7 * FRAME);

        // Leave critical while the display is in a dark phase
        wait_drive(1, 1'b1, "wait_dark");
        start_req = 1'b1; start_lvl = 2'b11;
        run(2 * FRAME);

        // Enable drop during column 1 drive, then re-enable
        wait_drive(1, 1'b0, "wait_col1");
        want_en = 1'b0;
        run(5);
        want_en = 1'b1;
        run(FRAME + 4);

        // Asynchronous reset during column 3 drive
        wait_drive(3, 1'b0, "wait_col3");
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("async_reset_col_sel_n", 32'(col_sel_n), 32'h1F);
        check("async_reset_row_n",     32'(row_n),     32'h7F);
        check("async_reset_dec_data",  32'(dec_data),  32'h0);
        check("async_reset_ack_queue", 32'(ack_q.size()), 32'd0);
        ack_q.delete();
        m_run = 1'b0; m_t = 0; m_lvl = 2'b00; m_crit = 0; m_ack_prev = 1'b0;
        want_en = 1'b0; enable = 1'b0; level_valid = 1'b0;
        exp_q.push_back('{cs: 5'h1F, row: 7'h7F, fs: 1'b0, ack: 1'b0, dd: 2'b00});
        @(negedge clk);
        reset_n = 1'b1;
        want_en = 1'b1;
        apply_and_model();
        run(FRAME);

        // Randomized traffic: level requests and occasional enable drops
        for (int i = 0; i < 3000; i++) begin
            if (m_run) want_en = ($urandom_range(0, 299) != 0);
            else       want_en = ($urandom_range(0, 3) == 0);
            if (!level_valid && $urandom_range(0, 99) == 0) begin
                start_req = 1'b1;
                start_lvl = 2'($urandom_range(0, 3));
            end
            tick();
        end

        @(posedge clk);
        #2;
        check("ack_queue_drained", 32'(ack_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
